// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths.
package uart_pkg;

    localparam int unsigned UART_OS_RATE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_FREQ/(BAUD_RATE*UART_OS_RATE) clocks.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic Clk_Core,
    input  logic Rst_Core,
    input  logic restart,
    output logic tick
);

    localparam int unsigned OS_DIV = CLK_FREQ / (BAUD_RATE * UART_OS_RATE);
    localparam int unsigned CNT_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, optional even parity, valid/ready output with error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic                 Clk_Core,
    input  logic                 Rst_Core,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic                 Frame_Err,
    output logic                 Parity_Err,
    output logic                 Overrun_Err
);

    localparam int unsigned SC_W = $clog2(UART_OS_RATE);
    localparam int unsigned BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SC_W-1:0] SMP_MID  = SC_W'(UART_OS_RATE / 2 - 1);
    localparam logic [SC_W-1:0] SMP_LAST = SC_W'(UART_OS_RATE - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    uart_rx_state_t state, state_next;

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic                 restart;
    logic                 tick;
    logic                 mid_tick;
    logic                 bit_tick;
    logic                 stop_done;
    logic [SC_W-1:0]      sample_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;

    uart_os_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_os_tick (
        .Clk_Core(Clk_Core),
        .Rst_Core(Rst_Core),
        .restart (restart),
        .tick    (tick)
    );

    // Flops reset to 1 so the idle line never looks like a start edge after reset.
    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], Rx_Serial};
            rx_prev <= sync_q[1];
        end
    end

    assign rx_s      = sync_q[1];
    assign fall      = rx_prev & ~rx_s;
    assign mid_tick  = tick && (sample_cnt == SMP_MID);
    assign bit_tick  = tick && (sample_cnt == SMP_LAST);
    assign stop_done = (state == STOP) && bit_tick;

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START:   if (mid_tick) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_tick && (bit_cnt == BIT_LAST)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_tick) state_next = STOP;
            STOP:    if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sample counter realigns to mid-bit when the start bit is confirmed.
    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
        end else begin
            if (restart || (mid_tick && state == START)) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            if (restart) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end else if (state == DATA && bit_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            end else if (state == PARITY && bit_tick) begin
                par_bad <= rx_s ^ (^shreg);
            end
        end
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            Rx_Data     <= '0;
            Rx_Valid    <= 1'b0;
            Frame_Err   <= 1'b0;
            Parity_Err  <= 1'b0;
            Overrun_Err <= 1'b0;
        end else begin
            Frame_Err   <= 1'b0;
            Parity_Err  <= 1'b0;
            Overrun_Err <= 1'b0;
            if (Rx_Valid && Rx_Ready) begin
                Rx_Valid <= 1'b0;
            end
            if (stop_done) begin
                if (!rx_s) begin
                    Frame_Err <= 1'b1;
                end else if (par_bad) begin
                    Parity_Err <= 1'b1;
                end else if (Rx_Valid && !Rx_Ready) begin
                    Overrun_Err <= 1'b1;
                end else begin
                    Rx_Data  <= shreg;
                    Rx_Valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned BAUD = 10000;
    localparam int unsigned CLKF = 1280000;
    localparam int BIT = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser0 = 1'b1, ser1 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0, data1;
    logic valid0, valid1, ferr0, ferr1, perr0, perr1, oerr0, oerr1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY_EN(0)) dut0 (
        .Clk_Core(clk), .Rst_Core(rst), .Rx_Serial(ser0), .Rx_Data(data0),
        .Rx_Valid(valid0), .Rx_Ready(rdy0), .Frame_Err(ferr0), .Parity_Err(perr0),
        .Overrun_Err(oerr0));

    uart_rx #(.BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
        .Clk_Core(clk), .Rst_Core(rst), .Rx_Serial(ser1), .Rx_Data(data1),
        .Rx_Valid(valid1), .Rx_Ready(rdy1), .Frame_Err(ferr1), .Parity_Err(perr1),
        .Overrun_Err(oerr1));

    // Observed event counters, sampled on the falling edge.
    int hs_cnt[2]   = '{0, 0};
    int ferr_cnt[2] = '{0, 0};
    int perr_cnt[2] = '{0, 0};
    int oerr_cnt[2] = '{0, 0};
    logic [7:0] hs_data[2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        if (valid0 && rdy0) begin hs_cnt[0] <= hs_cnt[0] + 1; hs_data[0] <= data0; end
        if (valid1 && rdy1) begin hs_cnt[1] <= hs_cnt[1] + 1; hs_data[1] <= data1; end
        if (ferr0) ferr_cnt[0] <= ferr_cnt[0] + 1;
        if (ferr1) ferr_cnt[1] <= ferr_cnt[1] + 1;
        if (perr0) perr_cnt[0] <= perr_cnt[0] + 1;
        if (perr1) perr_cnt[1] <= perr_cnt[1] + 1;
        if (oerr0) oerr_cnt[0] <= oerr_cnt[0] + 1;
        if (oerr1) oerr_cnt[1] <= oerr_cnt[1] + 1;
    end

    // Reference model state, one entry per instance.
    int         e_hs[2]     = '{0, 0};
    int         e_ferr[2]   = '{0, 0};
    int         e_perr[2]   = '{0, 0};
    int         e_oerr[2]   = '{0, 0};
    logic [7:0] e_hsdata[2] = '{8'h00, 8'h00};
    logic [7:0] m_data[2]   = '{8'h00, 8'h00};
    int         m_valid[2]  = '{0, 0};

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rdy_of(input int s);
        return (s == 0) ? int'(rdy0) : int'(rdy1);
    endfunction

    task automatic drive(input int s, input logic v);
        if (s == 0) ser0 = v; else ser1 = v;
    endtask

    task automatic wait_bit();
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic pbit, input logic stopb);
        drive(s, 1'b0); wait_bit();
        for (int i = 0; i < 8; i++) begin drive(s, d[i]); wait_bit(); end
        if (s == 1) begin drive(s, pbit); wait_bit(); end
        drive(s, stopb); wait_bit();
    endtask

    task automatic model_frame(input int s, input logic [7:0] d, input logic pbit, input logic stopb);
        if (!stopb) e_ferr[s]++;
        else if (s == 1 && pbit != ^d) e_perr[s]++;
        else if (m_valid[s] != 0 && rdy_of(s) == 0) e_oerr[s]++;
        else begin
            m_data[s] = d;
            if (rdy_of(s) != 0) begin
                e_hs[s]++; e_hsdata[s] = d; m_valid[s] = 0;
            end else begin
                m_valid[s] = 1;
            end
        end
    endtask

    task automatic check_all(input int s, input string tag);
        chk($sformatf("%s.hs_count", tag), hs_cnt[s], e_hs[s]);
        chk($sformatf("%s.hs_data", tag), int'(hs_data[s]), int'(e_hsdata[s]));
        chk($sformatf("%s.frame_err", tag), ferr_cnt[s], e_ferr[s]);
        chk($sformatf("%s.parity_err", tag), perr_cnt[s], e_perr[s]);
        chk($sformatf("%s.overrun_err", tag), oerr_cnt[s], e_oerr[s]);
        chk($sformatf("%s.valid", tag), (s == 0) ? int'(valid0) : int'(valid1), m_valid[s]);
        chk($sformatf("%s.data", tag), (s == 0) ? int'(data0) : int'(data1), int'(m_data[s]));
    endtask

    task automatic frame(input int s, input logic [7:0] d, input logic pbit, input logic stopb,
                         input string tag);
        send(s, d, pbit, stopb);
        model_frame(s, d, pbit, stopb);
        check_all(s, tag);
    endtask

    task automatic set_ready(input int s, input logic v);
        @(posedge clk); #1;
        if (s == 0) rdy0 = v; else rdy1 = v;
        if (v && m_valid[s] != 0) begin
            e_hs[s]++; e_hsdata[s] = m_data[s]; m_valid[s] = 0;
        end
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       pb, sb;

        repeat (4) @(posedge clk);
        #1;
        chk("reset.valid0", int'(valid0), 0);
        chk("reset.data0", int'(data0), 0);
        chk("reset.errs0", int'({ferr0, perr0, oerr0}), 0);
        chk("reset.valid1", int'(valid1), 0);
        rst = 1'b0;
        wait_bit();

        frame(0, 8'hA5, 1'b0, 1'b1, "a5");

        drive(0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        drive(0, 1'b1);
        wait_bit(); wait_bit();
        check_all(0, "glitch");

        frame(0, 8'h3C, 1'b0, 1'b0, "stop_low");
        repeat (3) wait_bit();
        check_all(0, "held_low");
        drive(0, 1'b1); wait_bit();
        frame(0, 8'h96, 1'b0, 1'b1, "after_low");

        set_ready(0, 1'b0);
        frame(0, 8'h11, 1'b0, 1'b1, "ovr_first");
        frame(0, 8'h22, 1'b0, 1'b1, "ovr_second");
        set_ready(0, 1'b1);
        @(negedge clk);
        chk("ovr.valid_before_hs", int'(valid0), 1);
        @(negedge clk);
        chk("ovr.valid_after_hs", int'(valid0), 0);
        chk("ovr.hs_data", int'(hs_data[0]), 8'h11);
        @(posedge clk); #1;
        check_all(0, "ovr_done");

        frame(1, 8'h07, 1'b0, 1'b1, "par_bad");
        frame(1, 8'h07, 1'b1, 1'b1, "par_good");

        // Abort a frame during data bit 4, then receive a clean one.
        d = 8'h5A;
        drive(0, 1'b0); wait_bit();
        for (int i = 0; i < 4; i++) begin drive(0, d[i]); wait_bit(); end
        drive(0, d[4]);
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.valid", int'(valid0), 0);
        chk("rst_mid.data", int'(data0), 0);
        chk("rst_mid.errs", int'({ferr0, perr0, oerr0}), 0);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin m_valid[s] = 0; m_data[s] = 8'h00; end
        wait_bit(); wait_bit();
        check_all(0, "rst_idle");
        frame(0, 8'h5A, 1'b0, 1'b1, "after_rst");

        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 8; n++) begin
                set_ready(s, $urandom_range(0, 9) < 7);
                @(posedge clk); #1;
                d  = 8'($urandom);
                sb = ($urandom_range(0, 5) != 0);
                pb = (^d) ^ ($urandom_range(0, 3) == 0);
                frame(s, d, pb, sb, $sformatf("rand%0d_%0d", s, n));
                if (!sb) begin drive(s, 1'b1); wait_bit(); end
            end
            set_ready(s, 1'b1);
            @(posedge clk); @(posedge clk); #1;
            check_all(s, $sformatf("rand%0d_drain", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
